// File: rtl/mem_stage_pipelined.sv
// Memory stage of the five-stage pipeline: data memory, load/store lane formatting,
// wait-state controller that stalls upstream, and the M/W pipeline register.
module mem_stage_pipelined #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic              syscall_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [1:0]        mem_size_m,
    input  logic              mem_unsigned_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic [REG_W-1:0]  write_reg_m,
    output logic              stall_m,
    output logic              reg_write_m_hz,
    output logic [REG_W-1:0]  write_reg_m_hz,
    output logic              valid_w,
    output logic              syscall_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              misalign_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_out_w,
    output logic [REG_W-1:0]  write_reg_w
);
    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic       HAS_WAIT = (MEM_LATENCY > 0);
    localparam logic [3:0] CNT_INIT = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic              valid;
        logic              syscall;
        logic              reg_write;
        logic              mem_to_reg;
        logic              misalign;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  write_reg;
    } w_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [1:0]        size_q;
    logic              uns_q, wr_q;
    w_t                w_q, w_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              in_wait, req, misal_in, aligned_req, commit;
    logic [DATA_W-1:0] addr_e, wdata_e, rword, rdata, wd_rep;
    logic [1:0]        size_e, lane;
    logic              uns_e;
    logic [AW-1:0]     idx;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [3:0]        be;
    logic              unused_addr_bits;

    // While waiting, the memory side uses the request captured on entry.
    assign in_wait     = (state_q == WAIT);
    assign req         = valid_m & (mem_read_m | mem_write_m);
    assign misal_in    = ((mem_size_m == 2'b01) & alu_out_m[0]) | (mem_size_m[1] & (|alu_out_m[1:0]));
    assign aligned_req = req & ~misal_in;
    assign addr_e      = in_wait ? addr_q  : alu_out_m;
    assign wdata_e     = in_wait ? wdata_q : write_data_m;
    assign size_e      = in_wait ? size_q  : mem_size_m;
    assign uns_e       = in_wait ? uns_q   : mem_unsigned_m;
    assign lane        = addr_e[1:0];
    assign idx         = addr_e[AW+1:2];
    assign unused_addr_bits = ^addr_e[DATA_W-1:AW+2];

    assign stall_m = rst_n & ((~in_wait & aligned_req & HAS_WAIT) | (in_wait & (cnt_q != '0)));
    assign commit  = rst_n & ~stall_m & (in_wait ? wr_q : (aligned_req & mem_write_m));

    assign reg_write_m_hz = reg_write_m & valid_m;
    assign write_reg_m_hz = write_reg_m;

    always_comb begin
        rword = mem[idx];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (size_e)
            2'b00:   rdata = uns_e ? {{(DATA_W-8){1'b0}}, rbyte} : {{(DATA_W-8){rbyte[7]}}, rbyte};
            2'b01:   rdata = uns_e ? {{(DATA_W-16){1'b0}}, rhalf} : {{(DATA_W-16){rhalf[15]}}, rhalf};
            default: rdata = rword;
        endcase
        be     = 4'b0000;
        wd_rep = wdata_e;
        case (size_e)
            2'b00: begin
                be[lane] = 1'b1;
                wd_rep   = {4{wdata_e[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wdata_e[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wd_rep[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aligned_req & HAS_WAIT) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                        addr_q  <= alu_out_m;
                        wdata_q <= write_data_m;
                        size_q  <= mem_size_m;
                        uns_q   <= mem_unsigned_m;
                        wr_q    <= mem_write_m;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
                    else             state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_d = w_q;
        if (stall_m) begin
            w_d.valid     = 1'b0;
            w_d.syscall   = 1'b0;
            w_d.reg_write = 1'b0;
            w_d.misalign  = 1'b0;
        end else begin
            w_d.valid      = valid_m;
            w_d.syscall    = syscall_m;
            w_d.mem_to_reg = mem_to_reg_m;
            w_d.misalign   = req & misal_in;
            w_d.reg_write  = reg_write_m & valid_m & ~(req & misal_in);
            w_d.read_data  = (~in_wait & misal_in) ? '0 : rdata;
            w_d.alu_out    = alu_out_m;
            w_d.write_reg  = write_reg_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_q <= '0;
        else        w_q <= w_d;
    end

    assign valid_w      = w_q.valid;
    assign syscall_w    = w_q.syscall;
    assign reg_write_w  = w_q.reg_write;
    assign mem_to_reg_w = w_q.mem_to_reg;
    assign misalign_w   = w_q.misalign;
    assign read_data_w  = w_q.read_data;
    assign alu_out_w    = w_q.alu_out;
    assign write_reg_w  = w_q.write_reg;
endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Bench for mem_stage_pipelined: three instances (latency 0, 3, 4) checked every cycle
// against a byte-addressed transaction model, plus literal expectations from the test plan.
module tb_mem_stage_pipelined;
    typedef struct packed {
        logic        v, sys, rw, mtr, rd, wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] alu, wd;
        logic [4:0]  wreg;
    } min_t;

    typedef struct {
        logic        v, sys, rw, mtr, mis;
        logic [31:0] rd, alu;
        logic [4:0]  wreg;
        bit          rdok;
    } w_t;

    logic clk = 1'b0;
    logic rst_n;
    min_t mi [3];

    logic        stall [3], rwhz [3], vw [3], sysw [3], rww [3], mtrw [3], misw [3];
    logic [4:0]  wrhz [3], wregw [3];
    logic [31:0] rdw [3], aluw [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_pipelined #(
            .DATA_W(32), .REG_W(5), .MEM_DEPTH(1024),
            .MEM_LATENCY((g == 0) ? 0 : ((g == 1) ? 3 : 4))
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .valid_m(mi[g].v), .syscall_m(mi[g].sys), .reg_write_m(mi[g].rw),
            .mem_to_reg_m(mi[g].mtr), .mem_read_m(mi[g].rd), .mem_write_m(mi[g].wr),
            .mem_size_m(mi[g].sz), .mem_unsigned_m(mi[g].un), .alu_out_m(mi[g].alu),
            .write_data_m(mi[g].wd), .write_reg_m(mi[g].wreg),
            .stall_m(stall[g]), .reg_write_m_hz(rwhz[g]), .write_reg_m_hz(wrhz[g]),
            .valid_w(vw[g]), .syscall_w(sysw[g]), .reg_write_w(rww[g]),
            .mem_to_reg_w(mtrw[g]), .misalign_w(misw[g]), .read_data_w(rdw[g]),
            .alu_out_w(aluw[g]), .write_reg_w(wregw[g])
        );
    end

    task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %h expected %h", n, i, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          lat [3] = '{0, 3, 4};
    logic [7:0]  mm [3][4096];
    bit          kn [3][4096];
    w_t          ew [3];
    bit          busy [3];
    int          done_cyc [3];
    min_t        cap [3];
    int          cyc = 0;

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            min_t        t;
            logic        req, mis, es;
            logic [31:0] val;
            int          ba, nb;
            bit          ok;
            if (!rst_n) begin
                ew[i] = '{v: 0, sys: 0, rw: 0, mtr: 0, mis: 0, rd: 0, alu: 0, wreg: 0, rdok: 1};
                busy[i] = 0;
            end
            chk("valid_w", i, vw[i], ew[i].v);
            chk("syscall_w", i, sysw[i], ew[i].sys);
            chk("reg_write_w", i, rww[i], ew[i].rw);
            chk("mem_to_reg_w", i, mtrw[i], ew[i].mtr);
            chk("misalign_w", i, misw[i], ew[i].mis);
            chk("alu_out_w", i, aluw[i], ew[i].alu);
            chk("write_reg_w", i, wregw[i], ew[i].wreg);
            if (ew[i].rdok) chk("read_data_w", i, rdw[i], ew[i].rd);
            if (!rst_n) begin
                chk("stall_m_rst", i, stall[i], 0);
                continue;
            end
            chk("reg_write_m_hz", i, rwhz[i], mi[i].rw & mi[i].v);
            chk("write_reg_m_hz", i, wrhz[i], mi[i].wreg);
            req = mi[i].v & (mi[i].rd | mi[i].wr);
            mis = req & misal(mi[i].sz, mi[i].alu);
            if (!busy[i] && req && !mis && lat[i] > 0) begin
                busy[i]     = 1;
                done_cyc[i] = cyc + lat[i];
                cap[i]      = mi[i];
            end
            es = busy[i] && (cyc < done_cyc[i]);
            chk("stall_m", i, stall[i], es);
            if (es) begin
                ew[i].v = 0; ew[i].sys = 0; ew[i].rw = 0; ew[i].mis = 0;
            end else begin
                t = busy[i] ? cap[i] : mi[i];
                busy[i] = 0;
                req = t.v & (t.rd | t.wr);
                mis = req & misal(t.sz, t.alu);
                ew[i].v = t.v; ew[i].sys = t.sys; ew[i].mtr = t.mtr; ew[i].mis = mis;
                ew[i].rw = t.rw & t.v & !mis;
                ew[i].alu = t.alu; ew[i].wreg = t.wreg;
                ew[i].rdok = 0;
                ba = int'(t.alu[11:0]);
                nb = nbytes(t.sz);
                if (req && !mis && t.rd) begin
                    val = 0; ok = 1;
                    for (int k = 0; k < nb; k++) begin
                        val[8*k +: 8] = mm[i][ba+k];
                        ok &= kn[i][ba+k];
                    end
                    if (nb == 1) val = t.un ? {24'd0, val[7:0]} : {{24{val[7]}}, val[7:0]};
                    if (nb == 2) val = t.un ? {16'd0, val[15:0]} : {{16{val[15]}}, val[15:0]};
                    ew[i].rd = val; ew[i].rdok = ok;
                end
                if (req && !mis && t.wr) begin
                    for (int k = 0; k < nb; k++) begin
                        mm[i][ba+k] = t.wd[8*k +: 8];
                        kn[i][ba+k] = 1;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic op(input int i, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic un, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] wreg, output int nst);
        bit fin = 0;
        mi[i] = '{v: 1'b1, sys: 1'b0, rw: rw, mtr: rd, rd: rd, wr: wr, sz: sz, un: un,
                  alu: a, wd: wd, wreg: wreg};
        nst = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall[i]) begin
                fin = 1;
                break;
            end
            nst++;
        end
        if (!fin) chk("op_timeout", i, 1, 0);
        @(posedge clk);
        #1;
        mi[i].v = 1'b0; mi[i].rd = 1'b0; mi[i].wr = 1'b0;
    endtask

    task automatic ld(input int i, input logic [1:0] sz, input logic un, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_nst);
        int n;
        op(i, 1'b1, 1'b0, sz, un, 1'b1, a, 32'h0, 5'd3, n);
        chk("load_value", i, rdw[i], exp);
        chk("load_stalls", i, n, exp_nst);
    endtask

    task automatic st(input int i, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input int exp_nst);
        int n;
        op(i, 1'b0, 1'b1, sz, 1'b0, 1'b0, a, d, 5'd0, n);
        chk("store_stalls", i, n, exp_nst);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) mi[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency 0: word round trip, lane formatting, misalignment, wrap, pass-through
        st(0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        st(0, 2'b10, 32'h20, 32'h80FF7F01, 0);
        ld(0, 2'b00, 1'b0, 32'h23, 32'hFFFFFF80, 0);
        ld(0, 2'b00, 1'b1, 32'h23, 32'h00000080, 0);
        ld(0, 2'b01, 1'b0, 32'h22, 32'hFFFF80FF, 0);
        ld(0, 2'b01, 1'b1, 32'h20, 32'h00007F01, 0);
        st(0, 2'b00, 32'h21, 32'h000000A5, 0);
        ld(0, 2'b10, 1'b0, 32'h20, 32'h80FFA501, 0);
        st(0, 2'b10, 32'h30, 32'h01020304, 0);
        st(0, 2'b01, 32'h31, 32'h0000ABCD, 0);
        chk("misalign_store", 0, misw[0], 1);
        chk("misalign_store_rw", 0, rww[0], 0);
        op(0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h21, 32'h0, 5'd4, n);
        chk("misalign_load", 0, misw[0], 1);
        chk("misalign_load_rw", 0, rww[0], 0);
        ld(0, 2'b10, 1'b0, 32'h30, 32'h01020304, 0);
        st(0, 2'b10, 32'h1000, 32'hCAFEF00D, 0);
        ld(0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 0);
        op(0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00ABCDEF, 32'h0, 5'd7, n);
        chk("alu_rw", 0, rww[0], 1);
        chk("alu_wreg", 0, wregw[0], 7);
        chk("alu_out", 0, aluw[0], 32'h00ABCDEF);
        chk("alu_valid", 0, vw[0], 1);

        // latency 3: stalls, back-to-back accesses
        st(1, 2'b10, 32'h40, 32'h55AA1234, 3);
        ld(1, 2'b10, 1'b0, 32'h40, 32'h55AA1234, 3);
        ld(1, 2'b10, 1'b0, 32'h40, 32'h55AA1234, 3);
        ld(1, 2'b00, 1'b1, 32'h41, 32'h00000012, 3);
        st(1, 2'b01, 32'h42, 32'h0000BEEF, 3);
        ld(1, 2'b10, 1'b0, 32'h40, 32'hBEEF1234, 3);
        op(1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h43, 32'h0, 5'd0, n);
        chk("misalign_no_stall", 1, n, 0);

        // latency 4: reset during the second stall cycle aborts the store
        st(2, 2'b10, 32'h50, 32'h11111111, 4);
        mi[2] = '{v: 1'b1, sys: 1'b0, rw: 1'b0, mtr: 1'b0, rd: 1'b0, wr: 1'b1, sz: 2'b10,
                  un: 1'b0, alu: 32'h50, wd: 32'h12345678, wreg: 5'd0};
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall", 2, stall[2], 0);
        chk("rst_valid_w", 2, vw[2], 0);
        chk("rst_alu_out_w", 2, aluw[2], 0);
        mi[2] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ld(2, 2'b10, 1'b0, 32'h50, 32'h11111111, 4);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_pipelined.md
# mem_stage_pipelined

Parametrised memory stage for the five-stage MIPS pipeline. It contains the data memory array, the M/W pipeline register, byte/halfword/word load-store formatting and a wait-state controller that stalls the pipeline for a configurable memory latency. It sits between the execute-stage M register and the writeback stage. It also reports M-stage destination information to the hazard unit.

## Interface
Parameters:
- DATA_W, 32: data and address width; only 32 is supported.
- REG_W, 5: register-index width.
- MEM_DEPTH, 1024: data memory depth in 32-bit words; must be a power of 2.
- MEM_LATENCY, 0: wait states per access, range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_m  input  1  M-stage instruction is valid
- syscall_m  input  1  instruction is a syscall
- reg_write_m  input  1  instruction writes the register file
- mem_to_reg_m  input  1  writeback selects memory data
- mem_read_m  input  1  load
- mem_write_m  input  1  store
- mem_size_m  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- mem_unsigned_m  input  1  zero-extend loads; 0 means sign-extend
- alu_out_m  input  DATA_W  effective address or ALU result
- write_data_m  input  DATA_W  store data, right-aligned
- write_reg_m  input  REG_W  destination register
- stall_m  output  1  memory busy; upstream holds the M register and F/D/E stages
- reg_write_m_hz  output  1  reg_write_m & valid_m, to the hazard unit
- write_reg_m_hz  output  REG_W  write_reg_m, to the hazard unit
- valid_w, syscall_w, reg_write_w, mem_to_reg_w, misalign_w  output  1  registered W-stage controls
- read_data_w  output  DATA_W  formatted load data
- alu_out_w  output  DATA_W  registered alu_out_m
- write_reg_w  output  REG_W  registered destination

## Operation
- A request exists when valid_m & (mem_read_m | mem_write_m).
- Word index is alu_out_m[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH words.
- Addressing is little-endian. The byte lane is alu_out_m[1:0].
  - Stores: byte writes one lane; half writes lanes {a1,a0}={x,0} pair; word writes all four lanes.
  - Loads: the selected lane or pair is extracted and sign- or zero-extended. Words are passed unchanged.
- Misalignment: half with a0=1, or word with a1|a0≠0.
  - No memory access and no stall.
  - The store is suppressed.
  - W receives misalign_w=1 and reg_write_w=0. Other fields pass through.
- FSM states:
  - IDLE: on a request with MEM_LATENCY>0 and an aligned address, go to WAIT and load cnt=MEM_LATENCY−1. Otherwise complete in the same cycle.
  - WAIT: while cnt≠0, decrement cnt. When cnt==0, complete and return to IDLE.
- stall_m = (IDLE & request & aligned & MEM_LATENCY>0) | (WAIT & cnt≠0). It is combinational.
- Completion cycle:
  - The store commits to the array at the clock edge.
  - Load data is read combinationally from the array and registered into read_data_w.
  - All W fields load from the M inputs.
- While stall_m=1, W receives a bubble each cycle: valid_w=0, reg_write_w=0, syscall_w=0, misalign_w=0. Data fields hold.
- Non-memory instructions and invalid slots pass to W in one cycle. valid_w = valid_m, and reg_write_w is gated by valid_m.
- While stall_m=1, M inputs are required to stay stable. Changes are ignored until completion; the captured address and data are the cycle-t values.

## Timing
- Request in cycle t:
  - stall_m=1 in cycles t..t+MEM_LATENCY−1.
  - stall_m=0 in cycle t+MEM_LATENCY.
  - W outputs update at the edge ending cycle t+MEM_LATENCY.
  - Load-to-W latency is MEM_LATENCY+1 edges.
- MEM_LATENCY=0: fully single-cycle, and stall_m stays 0.
- Back-to-back requests: the next request is accepted in the cycle after completion, with no dead cycle.
- Read-after-write to the same word in consecutive instructions returns the newly stored data, because the store commits at the edge before the next read.
- Reset (asynchronous, any state):
  - FSM returns to IDLE and cnt=0.
  - All W outputs become 0 and stall_m becomes 0 once rst_n=0.
  - A store in WAIT is aborted and not committed.
  - Memory contents are not reset.

## Test plan
- MEM_LATENCY=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 → stall_m never 1; read_data_w=0xDEADBEEF one edge after the load.
- Byte and half loads: memory word at 0x20 = 0x80FF7F01.
  - lb at 0x23 → 0xFFFFFF80.
  - lbu at 0x23 → 0x00000080.
  - lh at 0x22 → 0xFFFF80FF.
  - lhu at 0x20 → 0x00007F01.
- MEM_LATENCY=3: load at 0x40 → stall_m=1 for exactly 3 cycles; W bubbles (valid_w=0) during those cycles; W valid with data on the 4th edge. A second load follows with stall in the next cycle.
- Misaligned: sh at 0x31 with data 0xABCD → word at 0x30 unchanged; misalign_w=1, reg_write_w=0, stall_m=0.
- Reset mid-access: MEM_LATENCY=4, sw 0x12345678 to 0x50, assert rst_n=0 during the 2nd stall cycle → stall_m and all W outputs drop to 0; a later load of 0x50 returns the old contents.
- Wrap and pass-through: MEM_DEPTH=1024, sw 0xCAFEF00D at 0x1000 then lw at 0x0 → 0xCAFEF00D. An ALU op with reg_write_m=1, write_reg_m=7 → reg_write_w=1, write_reg_w=7, alu_out_w equal to the input, one edge later.
